// File: rtl/seg7_pkg.sv
// Shared types, glyph constants and sizing helper for the multiplexed seven-segment driver.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // {g,f,e,d,c,b,a} glyphs for 0-9 then A-F
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Counter width large enough to hold the longest slot phase without wrapping.
    function automatic int unsigned cnt_width(input int unsigned refresh_div,
                                              input int unsigned blank_cycles);
        int unsigned m;
        m = 1;
        if (refresh_div > m) m = refresh_div;
        if (blank_cycles > m) m = blank_cycles;
        return int'($clog2(m + 1));
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display bus of the scan driver: value/control inputs and the segment/digit outputs.
interface seg7_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 3
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      hex_mode;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     dig_en;
    logic                      frame_start;

    modport master (
        output enable, load, value_in, dp_in, hex_mode,
        input  seg, dp, dig_en, frame_start
    );

    modport slave (
        input  enable, load, value_in, dp_in, hex_mode,
        output seg, dp, dig_en, frame_start
    );
endinterface

// File: rtl/seg7_glyph_rom.sv
// Nibble to seven-segment glyph lookup; A-F become a dash unless hex_mode is set.
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] glyph_c
);

    always_comb begin
        glyph_c = GLYPH_TABLE[nibble];
        if (!hex_mode && (nibble > 4'd9)) glyph_c = SEG_DASH;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-cathode seven-segment scanner with blanking guard and tear-free loading.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 3,
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    seg7_scan_driver_if.slave   bus
);

    localparam int unsigned VAL_W      = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W      = cnt_width(REFRESH_DIV, BLANK_CYCLES);
    localparam int unsigned SHOW_LAST  = REFRESH_DIV - 1;
    localparam int unsigned BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam int unsigned IDX_LAST   = NUM_DIGITS - 1;
    localparam state_t      FIRST_STATE = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [VAL_W-1:0]       pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]  pend_dp_q, pend_dp_d;
    logic [VAL_W-1:0]       act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]  act_dp_q, act_dp_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]  dig_en_q, dig_en_d;
    logic                   fs_q, fs_d;

    logic                   frame_edge;
    logic [VAL_W-1:0]       src_val;
    logic [NUM_DIGITS-1:0]  src_dp;
    logic [3:0]             nib;
    logic                   dp_sel;
    logic                   lz_blank;
    logic [6:0]             glyph_c;
`ifdef LEADING_ZERO_BLANK_EN
    logic                   zero_above;
`endif

    // On the frame edge the display reads the value that active is about to take,
    // so a zero-length blank phase still shows the new frame from its first cycle.
    always_comb begin
        frame_edge = bus.enable && (state_q == FIRST_STATE) &&
                     (idx_q == '0) && (cnt_q == '0);
        src_val = act_val_q;
        src_dp  = act_dp_q;
        if (frame_edge) begin
            src_val = bus.load ? bus.value_in : pend_val_q;
            src_dp  = bus.load ? bus.dp_in    : pend_dp_q;
        end
        nib    = 4'h0;
        dp_sel = 1'b0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib    = src_val[4*k +: 4];
                dp_sel = src_dp[k];
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        zero_above = 1'b1;
        lz_blank   = 1'b0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            zero_above = zero_above && (src_val[4*k +: 4] == 4'h0);
            if ((k > 0) && (idx_q == IDX_W'(k)) && zero_above) lz_blank = 1'b1;
        end
`else
        lz_blank = 1'b0;
`endif
    end

    seg7_glyph_rom u_glyph_rom (
        .nibble   (nib),
        .hex_mode (bus.hex_mode),
        .glyph_c  (glyph_c)
    );

    // Next-state and next-output logic; outputs are computed for the current state and registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        seg_d      = SEG_BLANK;
        dp_d       = 1'b0;
        dig_en_d   = '0;
        fs_d       = 1'b0;

        if (bus.load) begin
            pend_val_d = bus.value_in;
            pend_dp_d  = bus.dp_in;
        end

        if (frame_edge) begin
            act_val_d = src_val;
            act_dp_d  = src_dp;
            fs_d      = 1'b1;
        end

        if (bus.enable) begin
            unique case (state_q)
                BLANK: begin
                    if (cnt_q == CNT_W'(BLANK_LAST)) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    dig_en_d = NUM_DIGITS'(1) << idx_q;
                    seg_d    = lz_blank ? SEG_BLANK : glyph_c;
                    dp_d     = dp_sel;
                    if (cnt_q == CNT_W'(SHOW_LAST)) begin
                        state_d = FIRST_STATE;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_W'(IDX_LAST)) ? '0 : idx_q + IDX_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = FIRST_STATE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FIRST_STATE;
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b0;
            dig_en_q   <= '0;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            dig_en_q   <= dig_en_d;
            fs_q       <= fs_d;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.dig_en      = dig_en_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 3 digits, 4-cycle slots, 1-cycle blanking (15-cycle frame).
module tb_seg7_scan_driver;

    localparam int unsigned NUM_DIGITS = 3;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ_SEG = 7'h00;
`else
    localparam logic [6:0] LZ_SEG = 7'h3F;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    seg7_scan_driver_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected word is {frame_start, dig_en[2:0], dp, seg[6:0]}
    task automatic chk(input string tag, input logic [11:0] exp);
        logic [11:0] obs;
        obs = {bus.frame_start, bus.dig_en, bus.dp, bus.seg};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed fs/dig/dp/seg=%03h expected %03h", tag, obs, exp);
        end
    endtask

    task automatic set_load(input logic [11:0] v, input logic [2:0] d);
        bus.load     = 1'b1;
        bus.value_in = v;
        bus.dp_in    = d;
    endtask

    // One digit slot: blank cycle then four lit cycles; any pending load strobe ends after the first edge.
    task automatic expect_slot(input string tag, input int idx, input logic [6:0] sg,
                               input logic dpv, input logic fs);
        logic [2:0] en;
        en = 3'b001 << idx;
        tick();
        bus.load = 1'b0;
        chk({tag, "_blank"}, {fs, 3'b000, 1'b0, 7'h00});
        for (int c = 0; c < 4; c++) begin
            tick();
            chk(tag, {1'b0, en, dpv, sg});
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.enable   = 1'b1;
        bus.load     = 1'b0;
        bus.value_in = 12'h000;
        bus.dp_in    = 3'b000;
        bus.hex_mode = 1'b0;

        repeat (3) begin
            tick();
            chk("reset", 12'h000);
        end
        rst_n = 1'b1;

        // Frame 1: reset value 000; load 123 mid-frame must not tear this frame
        expect_slot("f1_d0", 0, 7'h3F, 1'b0, 1'b1);
        set_load(12'h123, 3'b010);
        expect_slot("f1_d1", 1, 7'h3F, 1'b0, 1'b0);
        expect_slot("f1_d2", 2, 7'h3F, 1'b0, 1'b0);

        // Frame 2: shows 123 with dp on digit 1; load A0F mid-frame
        expect_slot("f2_d0", 0, 7'h4F, 1'b0, 1'b1);
        set_load(12'hA0F, 3'b000);
        expect_slot("f2_d1", 1, 7'h5B, 1'b1, 1'b0);
        expect_slot("f2_d2", 2, 7'h06, 1'b0, 1'b0);

        // Frame 3: A0F with dash for letters
        expect_slot("f3_d0_dash", 0, 7'h40, 1'b0, 1'b1);
        expect_slot("f3_d1",      1, 7'h3F, 1'b0, 1'b0);
        expect_slot("f3_d2_dash", 2, 7'h40, 1'b0, 1'b0);

        // Frame 4: hex glyphs; two loads inside the frame, the later must win
        bus.hex_mode = 1'b1;
        expect_slot("f4_d0_hexF", 0, 7'h71, 1'b0, 1'b1);
        set_load(12'h111, 3'b000);
        expect_slot("f4_d1", 1, 7'h3F, 1'b0, 1'b0);
        set_load(12'h222, 3'b000);
        expect_slot("f4_d2_hexA", 2, 7'h77, 1'b0, 1'b0);

        // Frame 5: only 222 visible
        expect_slot("f5_d0", 0, 7'h5B, 1'b0, 1'b1);
        expect_slot("f5_d1", 1, 7'h5B, 1'b0, 1'b0);
        expect_slot("f5_d2", 2, 7'h5B, 1'b0, 1'b0);

        // Frame 6: load coincident with the frame edge shows immediately
        set_load(12'h333, 3'b000);
        expect_slot("f6_d0", 0, 7'h4F, 1'b0, 1'b1);
        expect_slot("f6_d1", 1, 7'h4F, 1'b0, 1'b0);
        expect_slot("f6_d2", 2, 7'h4F, 1'b0, 1'b0);

        // Frame 7: pause after two lit cycles of digit 1, load while paused, then resume
        expect_slot("f7_d0", 0, 7'h4F, 1'b0, 1'b1);
        tick();
        chk("f7_d1_blank", 12'h000);
        tick();
        chk("f7_d1_lit_a", {1'b0, 3'b010, 1'b0, 7'h4F});
        tick();
        chk("f7_d1_lit_b", {1'b0, 3'b010, 1'b0, 7'h4F});
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) set_load(12'h005, 3'b100);
            tick();
            bus.load = 1'b0;
            chk("paused_off", 12'h000);
        end
        bus.enable = 1'b1;
        tick();
        chk("resume_d1_a", {1'b0, 3'b010, 1'b0, 7'h4F});
        tick();
        chk("resume_d1_b", {1'b0, 3'b010, 1'b0, 7'h4F});
        expect_slot("f7_d2", 2, 7'h4F, 1'b0, 1'b0);

        // Frame 8: 005 loaded during the pause, dp on digit 2
        expect_slot("f8_d0", 0, 7'h6D, 1'b0, 1'b1);
        expect_slot("f8_d1_lz", 1, LZ_SEG, 1'b0, 1'b0);
        expect_slot("f8_d2_lz", 2, LZ_SEG, 1'b1, 1'b0);

        // Frame 9: all zero, digit 0 always shown
        set_load(12'h000, 3'b000);
        expect_slot("f9_d0", 0, 7'h3F, 1'b0, 1'b1);
        expect_slot("f9_d1_lz", 1, LZ_SEG, 1'b0, 1'b0);
        expect_slot("f9_d2_lz", 2, LZ_SEG, 1'b0, 1'b0);

        // Frame 10: 105, the inner zero is not leading
        set_load(12'h105, 3'b000);
        expect_slot("f10_d0", 0, 7'h6D, 1'b0, 1'b1);
        expect_slot("f10_d1", 1, 7'h3F, 1'b0, 1'b0);
        expect_slot("f10_d2", 2, 7'h06, 1'b0, 1'b0);

        // Reset mid-scan clears outputs on the next edge
        expect_slot("f11_d0", 0, 7'h6D, 1'b0, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("midscan_reset", 12'h000);
        rst_n = 1'b1;
        expect_slot("post_reset_d0", 0, 7'h3F, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
